// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit-side feeder.
//   BYTE_W          data width of one UART character
//   feeder_state_t  feeder FSM encoding (IDLE -> SEND -> GAP -> IDLE)
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    FD_IDLE = 2'd0,
    FD_SEND = 2'd1,
    FD_GAP  = 2'd2
  } feeder_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: groups the host-side write port and the transmitter
// handshake of the feeder into one bundle.
//   Host side : wr_en, wr_data, clr_ovf -> feeder; full, empty, count, overflow <- feeder
//   TX side   : donetx -> feeder; newd, dintx <- feeder
//   Status    : busy <- feeder
// Modports:
//   master - the environment (host plus transmitter)
//   slave  - the feeder itself
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              clr_ovf;
  logic              donetx;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              newd;
  logic [BYTE_W-1:0] dintx;
  logic              busy;

  modport master (
    output wr_en, wr_data, clr_ovf, donetx,
    input  full, empty, count, overflow, newd, dintx, busy
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, donetx,
    output full, empty, count, overflow, newd, dintx, busy
  );

endinterface : uart_tx_feeder_if

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO.
//   clk, rst   clock; asynchronous active-high reset of pointers and count
//   push       write request; accepted when not full, or when a pop happens
//              in the same cycle (a slot frees on the same edge)
//   push_data  data written on an accepted push
//   pop        read request; ignored when empty
//   head       oldest entry, valid whenever empty=0 (show-ahead)
//   count      entries held, 0..DEPTH
//   full/empty decoded combinationally from count
//   push_ok    high when the current push is accepted
// Storage contents are not reset; only pointers and count are.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int BYTE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [BYTE_W-1:0]          push_data,
  input  logic                       pop,
  output logic [BYTE_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       push_ok
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              pop_ok;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Pointers are ADDR_W bits and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
    end
  end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte queue and newd/donetx handshake in front of a UART
// transmitter. The host may burst bytes at clk rate; they are handed to the
// transmitter one frame at a time.
//   clk   system clock (the transmitter's uclk is derived from it)
//   rst   asynchronous active-high reset; drops newd immediately and
//         discards anything queued
//   bus   uart_tx_feeder_if.slave:
//           wr_en/wr_data  host write, one byte per cycle
//           clr_ovf        clears the sticky overflow flag
//           donetx         transmitter frame-complete level
//           full/empty     queue state; count excludes the byte in flight
//           overflow       sticky, set by a write dropped because full
//           newd/dintx     byte offered to the transmitter, held per frame
//           busy           FSM outside IDLE
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_feeder_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  feeder_state_t     state_reg;
  feeder_state_t     state_next;
  logic              newd_reg;
  logic              newd_next;
  logic [BYTE_W-1:0] dintx_reg;
  logic [BYTE_W-1:0] dintx_next;
  logic              donetx_q_reg;
  logic              overflow_reg;
  logic              done_rise;
  logic              pop;
  logic              push_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic [ADDR_W:0]   fifo_count;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .BYTE_W (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

  // donetx comes from uclk, itself derived from clk, so it is already
  // synchronous; a single register is enough for edge detection.
  assign done_rise = bus.donetx & ~donetx_q_reg;

  always_comb begin
    state_next = state_reg;
    newd_next  = newd_reg;
    dintx_next = dintx_reg;
    pop        = 1'b0;
    case (state_reg)
      FD_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          dintx_next = fifo_head;
          newd_next  = 1'b1;
          state_next = FD_SEND;
        end
      end
      FD_SEND: begin
        // Only a fresh rise ends the frame; a level left high from the
        // previous frame must not complete this one.
        if (done_rise) begin
          newd_next  = 1'b0;
          state_next = FD_GAP;
        end
      end
      FD_GAP: begin
        // Hold off the next newd until donetx falls, so the transmitter
        // never sees newd while it still reports the old frame done.
        if (!bus.donetx) begin
          state_next = FD_IDLE;
        end
      end
      default: begin
        newd_next  = 1'b0;
        state_next = FD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FD_IDLE;
      newd_reg     <= 1'b0;
      dintx_reg    <= '0;
      donetx_q_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      newd_reg     <= newd_next;
      dintx_reg    <= dintx_next;
      donetx_q_reg <= bus.donetx;
      // A dropped write takes priority over a simultaneous clear.
      if (bus.wr_en && !push_ok) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_reg;
  assign bus.newd     = newd_reg;
  assign bus.dintx    = dintx_reg;
  assign bus.busy     = (state_reg != FD_IDLE);

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed self-checking bench for uart_tx_feeder.
// The transmitter side is played directly by the bench: it watches newd and
// dintx and drives donetx high for two clk (about one uclk) per frame.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs changed after this are seen at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_newd(input string tag);
    for (int i = 0; i < 20 && bus.newd !== 1'b1; i++) tick();
    check(tag, 32'(bus.newd), 32'd1);
  endtask

  // Play one transmitter frame for the byte currently offered.
  task automatic do_frame(input string tag, input logic [7:0] exp_byte);
    wait_newd({tag, "_newd"});
    check({tag, "_dintx"}, 32'(bus.dintx), 32'(exp_byte));
    bus.donetx = 1'b1;
    tick();
    check({tag, "_gap_newd"}, 32'(bus.newd), 32'd0);
    tick();
    bus.donetx = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.clr_ovf  = 1'b0;
    bus.donetx   = 1'b0;
    tick();
    tick();
    check("rst_newd",     32'(bus.newd),     32'd0);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_dintx",    32'(bus.dintx),    32'h00);
    rst = 1'b0;
    tick();

    // 1: single byte, two-clock latency to newd, held until donetx rises
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("t1_count_1",  32'(bus.count), 32'd1);
    check("t1_newd_lat1", 32'(bus.newd), 32'd0);
    tick();
    check("t1_newd",  32'(bus.newd),  32'd1);
    check("t1_dintx", 32'(bus.dintx), 32'hA5);
    check("t1_count_0", 32'(bus.count), 32'd0);
    tick(); tick(); tick();
    check("t1_newd_held", 32'(bus.newd), 32'd1);
    bus.donetx = 1'b1;
    tick();
    check("t1_newd_drop", 32'(bus.newd), 32'd0);
    check("t1_busy_gap",  32'(bus.busy), 32'd1);
    tick();
    check("t1_gap_hold",  32'(bus.busy), 32'd1);
    bus.donetx = 1'b0;
    tick();
    check("t1_idle",      32'(bus.busy), 32'd0);

    // 2: back-to-back burst of three
    bus.wr_en = 1'b1; bus.wr_data = 8'h11;
    tick();
    bus.wr_data = 8'h22;
    tick();
    bus.wr_data = 8'h33;
    tick();
    bus.wr_en = 1'b0;
    check("t2_count_peak", 32'(bus.count), 32'd2);
    do_frame("t2_f11", 8'h11);
    do_frame("t2_f22", 8'h22);
    do_frame("t2_f33", 8'h33);
    check("t2_busy_end",  32'(bus.busy),  32'd0);
    check("t2_empty_end", 32'(bus.empty), 32'd1);

    // 3: 17 writes with no transmitter progress, then overflow
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("t3_count_16", 32'(bus.count), 32'd16);
    check("t3_full",     32'(bus.full),  32'd1);
    check("t3_inflight", 32'(bus.dintx), 32'h40);
    check("t3_ovf_pre",  32'(bus.overflow), 32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    check("t3_ovf_set",   32'(bus.overflow), 32'd1);
    check("t3_count_ovf", 32'(bus.count),    32'd16);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
    bus.wr_en = 1'b1; bus.clr_ovf = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
    check("t3_set_wins", 32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("t3_ovf_clr2", 32'(bus.overflow), 32'd0);

    // 4: write and pop in the same cycle while full
    bus.donetx = 1'b1;
    tick();
    bus.donetx = 1'b0;
    tick();
    check("t4_idle_full", 32'(bus.count), 32'd16);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    check("t4_count",    32'(bus.count),    32'd16);
    check("t4_overflow", 32'(bus.overflow), 32'd0);
    check("t4_newd",     32'(bus.newd),     32'd1);
    check("t4_dintx",    32'(bus.dintx),    32'h41);

    // 5: asynchronous reset mid-frame with bytes queued
    #2 rst = 1'b1;
    #1;
    check("t5_newd_async",  32'(bus.newd),     32'd0);
    check("t5_count_async", 32'(bus.count),    32'd0);
    check("t5_ovf_async",   32'(bus.overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("t5_no_frame", 32'(bus.newd), 32'd0);
    check("t5_idle",     32'(bus.busy), 32'd0);

    // 6: donetx activity while idle/empty, then a write under a high donetx
    bus.donetx = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t6_idle_newd",  32'(bus.newd),  32'd0);
    check("t6_idle_empty", 32'(bus.empty), 32'd1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    tick();
    check("t6_newd",  32'(bus.newd),  32'd1);
    check("t6_dintx", 32'(bus.dintx), 32'h5A);
    tick(); tick(); tick();
    check("t6_stale_level", 32'(bus.newd), 32'd1);
    bus.donetx = 1'b0;
    tick();
    check("t6_low", 32'(bus.newd), 32'd1);
    bus.donetx = 1'b1;
    tick();
    check("t6_rise_drop", 32'(bus.newd), 32'd0);
    tick();
    bus.donetx = 1'b0;
    tick();
    check("t6_busy_end", 32'(bus.busy), 32'd0);
    tick(); tick(); tick();
    check("t6_once", 32'(bus.newd), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_feeder
